// File: rtl/univ_shift_pkg.sv
// ============================================================================
// Module : univ_shift_pkg
// Brief  : Mode encodings and counter-width helper for univ_shift_reg.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package univ_shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Enough bits to hold every count from 0 up to and including width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_sat_cnt.sv
// ============================================================================
// Module : shift_sat_cnt
// Brief  : Saturating up-counter with synchronous clear and clock enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shift_sat_cnt #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] c_MAX = W'(MAX);

  logic [W-1:0] r_cnt;

  // Clear has priority over increment; the count parks at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_inc && (r_cnt != c_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module : univ_shift_reg
// Brief  : WIDTH-bit universal shift register (hold/shr/shl/load) with shift
//          counter; define UNIV_SHIFT_ROTATE_EN to add the rot input.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef UNIV_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] ins,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] outs,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             drained
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_next;
  logic             w_shr_in;
  logic             w_shl_in;
  logic             w_is_shift;
  logic             w_is_load;

`ifdef UNIV_SHIFT_ROTATE_EN
  assign w_shr_in = rot ? r_data[0]       : sin_r;
  assign w_shl_in = rot ? r_data[WIDTH-1] : sin_l;
`else
  assign w_shr_in = sin_r;
  assign w_shl_in = sin_l;
`endif

  always_comb begin
    w_next = r_data;
    unique case (mode)
      MODE_SHR:  w_next = {w_shr_in, r_data[WIDTH-1:1]};
      MODE_SHL:  w_next = {r_data[WIDTH-2:0], w_shl_in};
      MODE_LOAD: w_next = ins;
      default:   w_next = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (en) begin
      r_data <= w_next;
    end
  end

  assign w_is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);
  assign w_is_load  = (mode == MODE_LOAD);

  shift_sat_cnt #(
    .MAX (WIDTH),
    .W   (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (en),
    .i_clr (w_is_load),
    .i_inc (w_is_shift),
    .o_cnt (shift_cnt)
  );

  assign outs    = r_data;
  assign sout_r  = r_data[0];
  assign sout_l  = r_data[WIDTH-1];
  assign drained = (shift_cnt == CNT_W'(WIDTH));

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module : tb_univ_shift_reg
// Brief  : Directed self-checking bench for univ_shift_reg (WIDTH=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] ins = 4'b0000;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic [3:0] outs;
  logic       sout_r;
  logic       sout_l;
  logic [2:0] shift_cnt;
  logic       drained;
`ifdef UNIV_SHIFT_ROTATE_EN
  logic       rot = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef UNIV_SHIFT_ROTATE_EN
    .rot       (rot),
`endif
    .en        (en),
    .mode      (mode),
    .ins       (ins),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .outs      (outs),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .shift_cnt (shift_cnt),
    .drained   (drained)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic e, input logic [1:0] m, input logic [3:0] d,
                     input logic sr, input logic sl);
    en = e; mode = m; ins = d; sin_r = sr; sin_l = sl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Power-on reset
    #2;
    check("rst_outs", outs, 4'b0000);
    check("rst_cnt", shift_cnt, 3'd0);
    check("rst_drained", drained, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Async reset mid-cycle while a shift is pending
    cyc(1'b1, 2'b11, 4'b1010, 1'b0, 1'b0);
    check("load_1010", outs, 4'b1010);
    en = 1'b1; mode = 2'b01; sin_r = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_outs", outs, 4'b0000);
    check("async_cnt", shift_cnt, 3'd0);
    check("async_drained", drained, 1'b0);
    @(posedge clk); #1;
    check("held_in_rst", outs, 4'b0000);
    #2 rst_n = 1'b1;

    // Load then right-shift drain
    cyc(1'b1, 2'b11, 4'b1011, 1'b0, 1'b0);
    check("load_1011", outs, 4'b1011);
    check("sout_r_0", sout_r, 1'b1);
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1);
    check("shr1_outs", outs, 4'b0101);
    check("sout_r_1", sout_r, 1'b1);
    check("shr1_cnt", shift_cnt, 3'd1);
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1);
    check("sout_r_2", sout_r, 1'b0);
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1);
    check("sout_r_3", sout_r, 1'b1);
    check("shr3_cnt", shift_cnt, 3'd3);
    check("shr3_drained", drained, 1'b0);
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1);
    check("shr4_outs", outs, 4'b0000);
    check("shr4_cnt", shift_cnt, 3'd4);
    check("shr4_drained", drained, 1'b1);
    cyc(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0);
    check("shr5_outs", outs, 4'b1000);
    check("shr5_cnt_sat", shift_cnt, 3'd4);
    check("shr5_sout_l", sout_l, 1'b1);

    // Left-shift deserialise 1,0,0,1
    cyc(1'b1, 2'b11, 4'b0000, 1'b0, 1'b0);
    check("load_0000_cnt", shift_cnt, 3'd0);
    cyc(1'b1, 2'b10, 4'b1111, 1'b1, 1'b1);
    check("shl1_outs", outs, 4'b0001);
    cyc(1'b1, 2'b10, 4'b1111, 1'b1, 1'b0);
    cyc(1'b1, 2'b10, 4'b1111, 1'b1, 1'b0);
    check("shl3_outs", outs, 4'b0100);
    cyc(1'b1, 2'b10, 4'b1111, 1'b1, 1'b1);
    check("shl4_outs", outs, 4'b1001);
    check("shl4_drained", drained, 1'b1);

    // Enable off, then hold mode
    cyc(1'b1, 2'b11, 4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b01, 4'b0000, 1'b1, 1'b1);
      check("en0_outs", outs, 4'b0110);
      check("en0_cnt", shift_cnt, 3'd0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 2'b00, 4'b0000, 1'b1, 1'b1);
      check("hold_outs", outs, 4'b0110);
      check("hold_cnt", shift_cnt, 3'd0);
    end

    // Load overrides count
    cyc(1'b1, 2'b10, 4'b0000, 1'b1, 1'b0);
    check("mix1_outs", outs, 4'b1100);
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1);
    check("mix2_outs", outs, 4'b0110);
    check("mix2_cnt", shift_cnt, 3'd2);
    cyc(1'b1, 2'b11, 4'b1111, 1'b0, 1'b0);
    check("reload_outs", outs, 4'b1111);
    check("reload_cnt", shift_cnt, 3'd0);
    check("reload_drained", drained, 1'b0);
    cyc(1'b0, 2'b11, 4'b0000, 1'b0, 1'b0);
    check("en0_load_blocked", outs, 4'b1111);

`ifdef UNIV_SHIFT_ROTATE_EN
    cyc(1'b1, 2'b11, 4'b1000, 1'b0, 1'b0);
    rot = 1'b1;
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
    check("rot1", outs, 4'b0100);
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
    check("rot2", outs, 4'b0010);
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
    check("rot3", outs, 4'b0001);
    cyc(1'b1, 2'b01, 4'b0000, 1'b0, 1'b0);
    check("rot4", outs, 4'b1000);
    check("rot4_drained", drained, 1'b1);
    cyc(1'b1, 2'b10, 4'b0000, 1'b0, 1'b0);
    check("rotl", outs, 4'b0001);
    check("rotl_cnt", shift_cnt, 3'd4);
    rot = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
